// File: rtl/round_sequencer.sv
// Byte-serial hash sequencer: absorbs message bytes over valid/ready and runs
// NUM_ROUNDS nibble-vector Round iterations per byte on the 8x4-bit state h.
module round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter logic [31:0] IV         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  msg_data,
  input  logic        msg_last,
  output logic        busy,
  output logic        digest_valid,
  output logic [31:0] digest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ABSORB,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] h;
  logic [31:0] h_round;
  logic [3:0]  rnd;
  logic [3:0]  sbox_out;
  logic [7:0]  byte_q;
  logic        last_q;
  logic [31:0] digest_q;
  logic        digest_valid_q;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;
      4'h1: sbox = 4'h5;
      4'h2: sbox = 4'h6;
      4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;
      4'h5: sbox = 4'h0;
      4'h6: sbox = 4'hA;
      4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;
      4'h9: sbox = 4'hE;
      4'hA: sbox = 4'hF;
      4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;
      4'hD: sbox = 4'h7;
      4'hE: sbox = 4'h1;
      default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] n);
    case (n)
      2'd0: rotl4 = x;
      2'd1: rotl4 = {x[2:0], x[3]};
      2'd2: rotl4 = {x[1:0], x[3:2]};
      default: rotl4 = {x[0], x[3:1]};
    endcase
  endfunction

  // Round datapath: every output nibble takes the input nibble two lanes up,
  // mixes in the S-box word, and rotates by half its lane index.
  always_comb begin
    sbox_out = sbox(byte_q[7:4] ^ byte_q[3:0] ^ rnd);
    h_round  = '0;
    for (int i = 0; i < 8; i++) begin
      h_round[4*i +: 4] = rotl4(h[4*((i + 2) % 8) +: 4] ^ sbox_out, 2'(i / 2));
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_LOAD;
      S_LOAD:   state_next = S_ABSORB;
      S_ABSORB: if (msg_valid) state_next = S_ROUND;
      S_ROUND: begin
        if (rnd == LAST_RND) state_next = last_q ? S_DONE : S_ABSORB;
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h              <= '0;
      rnd            <= '0;
      byte_q         <= '0;
      last_q         <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) digest_valid_q <= 1'b0;
        end
        S_LOAD: begin
          h <= IV;
        end
        S_ABSORB: begin
          if (msg_valid) begin
            byte_q <= msg_data;
            last_q <= msg_last;
            rnd    <= '0;
          end
        end
        S_ROUND: begin
          h   <= h_round;
          rnd <= rnd + 4'd1;  // wraps 15->0 on the final pass when NUM_ROUNDS=16
        end
        S_DONE: begin
          digest_q       <= h;
          digest_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // busy covers DONE so it falls exactly when digest_valid rises.
  assign msg_ready    = (state == S_ABSORB);
  assign busy         = (state != S_IDLE);
  assign digest_valid = digest_valid_q;
  assign digest       = digest_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed and randomised bench for round_sequencer: one instance with a single
// round and zero IV, one with 16 rounds and a non-zero IV.
module tb_round_sequencer;

  localparam logic [31:0] IV16 = 32'hA5C3_0F96;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start1 = 1'b0, valid1 = 1'b0, last1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        ready1, busy1, dv1;
  logic [31:0] digest1;

  logic        start = 1'b0, valid = 1'b0, last = 1'b0;
  logic [7:0]  data = '0;
  logic        ready, busy, dv;
  logic [31:0] digest;

  int checks = 0;
  int errors = 0;

  logic [7:0] mbuf [64];

  always #5 clk = ~clk;

  round_sequencer #(.NUM_ROUNDS(1), .IV(32'h0000_0000)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .msg_valid(valid1), .msg_ready(ready1),
    .msg_data(data1), .msg_last(last1), .busy(busy1), .digest_valid(dv1), .digest(digest1)
  );

  round_sequencer #(.NUM_ROUNDS(16), .IV(IV16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .msg_valid(valid), .msg_ready(ready),
    .msg_data(data), .msg_last(last), .busy(busy), .digest_valid(dv), .digest(digest)
  );

  function automatic logic [31:0] model_byte(input logic [31:0] hin, input logic [7:0] b,
                                             input int nr);
    logic [31:0] hc, hn;
    logic [3:0]  s, x;
    hc = hin;
    for (int r = 0; r < nr; r++) begin
      s = SBOX[b[7:4] ^ b[3:0] ^ 4'(r)];
      for (int i = 0; i < 8; i++) begin
        x = hc[4*((i + 2) % 8) +: 4] ^ s;
        for (int k = 0; k < i / 2; k++) x = {x[2:0], x[3]};
        hn[4*i +: 4] = x;
      end
      hc = hn;
    end
    return hc;
  endfunction

  function automatic logic [31:0] model_msg(input int n);
    logic [31:0] hc;
    hc = IV16;
    for (int j = 0; j < n; j++) hc = model_byte(hc, mbuf[j], 16);
    return hc;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit done = 0;
    valid = 1'b1;
    data  = d;
    last  = l;
    for (int c = 0; c < 100 && !done; c++) begin
      if (ready) done = 1;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_byte timeout data=%h", d);
    end
  endtask

  task automatic wait_digest(input string name, input logic [31:0] exp);
    bit got = 0;
    for (int c = 0; c < 200; c++) begin
      if (dv) begin got = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s digest_valid timeout", name);
    end else if (digest !== exp) begin
      errors++;
      $display("FAIL %s digest=%h expected=%h", name, digest, exp);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, dv, digest, ready1, busy1, dv1, digest1} !== '0) begin
      errors++;
      $display("FAIL reset_state ready=%b busy=%b dv=%b digest=%h expected all zero",
               ready, busy, dv, digest);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_round();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
      errors++;
      $display("FAIL load_state busy=%b ready=%b expected busy=1 ready=0", busy1, ready1);
    end
    @(posedge clk); #1;
    checks++;
    if (ready1 !== 1'b1) begin
      errors++;
      $display("FAIL absorb_ready ready=%b expected 1", ready1);
    end
    valid1 = 1'b1; data1 = 8'h00; last1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dv1 !== 1'b0) begin
      errors++;
      $display("FAIL r1_early_valid dv=%b expected 0", dv1);
    end
    @(posedge clk); #1;
    checks++;
    if (dv1 !== 1'b1 || busy1 !== 1'b0 || digest1 !== 32'h6633_99CC) begin
      errors++;
      $display("FAIL r1_digest dv=%b busy=%b digest=%h expected dv=1 busy=0 digest=663399cc",
               dv1, busy1, digest1);
    end
  endtask

  task automatic test_two_byte_timing();
    int nr = 0, first = -1, second = -1;
    logic prev_busy = 1'b0;
    bit got = 0;
    mbuf[0] = 8'h00; mbuf[1] = 8'hFF;
    do_start();
    valid = 1'b1; data = mbuf[0]; last = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (ready) begin
        if (nr == 0) first = c; else second = c;
        nr++;
      end
      if (dv) begin
        got = 1;
        checks++;
        if (busy !== 1'b0 || prev_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_vs_valid busy=%b prev_busy=%b expected 0 and 1", busy, prev_busy);
        end
        break;
      end
      prev_busy = busy;
      @(posedge clk); #1;
      if (nr == 1) begin data = mbuf[1]; last = 1'b1; end
      else if (nr == 2) valid = 1'b0;
    end
    valid = 1'b0;
    checks++;
    if (!got || nr != 2 || second - first != 17) begin
      errors++;
      $display("FAIL ready_spacing got=%0d ready_cycles=%0d spacing=%0d expected 2 and 17",
               got, nr, second - first);
    end
    checks++;
    if (digest !== model_msg(2)) begin
      errors++;
      $display("FAIL two_byte_digest digest=%h expected=%h", digest, model_msg(2));
    end
  endtask

  task automatic test_ignored_inputs();
    valid = 1'b1; data = 8'h77; last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ready !== 1'b0 || dv !== 1'b1) begin
        errors++;
        $display("FAIL idle_valid ready=%b dv=%b expected ready=0 dv=1", ready, dv);
      end
      @(posedge clk); #1;
    end
    do_start();
    valid = 1'b0;
    checks++;
    if (ready !== 1'b0 || dv !== 1'b0) begin
      errors++;
      $display("FAIL start_with_valid ready=%b dv=%b expected 0 0", ready, dv);
    end
    mbuf[0] = 8'h3C; mbuf[1] = 8'hA1;
    send_byte(mbuf[0], 1'b0);
    @(posedge clk); #1;
    start = 1'b1; data = 8'hFF; last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0 || dv !== 1'b0) begin
      errors++;
      $display("FAIL start_in_round busy=%b ready=%b dv=%b expected 1 0 0", busy, ready, dv);
    end
    send_byte(mbuf[1], 1'b1);
    wait_digest("ignored_inputs_digest", model_msg(2));
  endtask

  task automatic test_back_to_back();
    do_start();
    checks++;
    if (dv !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart dv=%b busy=%b expected dv=0 busy=1", dv, busy);
    end
    mbuf[0] = 8'h5A;
    send_byte(mbuf[0], 1'b1);
    wait_digest("b2b_digest", model_msg(1));
  endtask

  task automatic test_random();
    int len;
    for (int m = 0; m < 6; m++) begin
      len = (m == 0) ? 1 : (m == 1) ? 64 : int'($urandom_range(2, 40));
      for (int j = 0; j < len; j++) mbuf[j] = 8'($urandom);
      do_start();
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        send_byte(mbuf[j], j == len - 1);
      end
      wait_digest($sformatf("random_msg%0d_len%0d", m, len), model_msg(len));
    end
  endtask

  task automatic test_reset_mid_round();
    do_start();
    send_byte(8'h10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({ready, busy, dv, digest, dv1, digest1} !== '0) begin
      errors++;
      $display("FAIL reset_mid_round ready=%b busy=%b dv=%b digest=%h dv1=%b digest1=%h expected 0",
               ready, busy, dv, digest, dv1, digest1);
    end
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b ready=%b expected 0 0", busy, ready);
    end
    mbuf[0] = 8'hC3;
    do_start();
    send_byte(mbuf[0], 1'b1);
    wait_digest("post_reset_digest", model_msg(1));
  endtask

  initial begin
    test_reset();
    test_single_round();
    test_two_byte_timing();
    test_ignored_inputs();
    test_back_to_back();
    test_random();
    test_reset_mid_round();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
